counter_sweep_ctrl: RTL and testbench
=====================================

Name: counter_sweep_ctrl

Overview:
- Sequences read-out of the per-FIFO push counter block.
- On a start pulse, once the FIFO datapath reports idle, it requests each FIFO index's count in turn (req/idx).
- Captures each returned count (valid_cont/data_cont), streams it out per index, and produces a running total plus a done pulse.
- Sits between the test/control logic and the counter block; it is the only driver of the counter's req/idx.

Parameters:
- BUFFER_DEPTH, 8, width of one count value (data_cont).
- IDX_WIDTH, 2, FIFO index width; NUM_FIFOS = 2**IDX_WIDTH (derived localparam, not overridable).
- TIMEOUT_CYCLES, 15, max cycles to wait for valid_cont; used only with the optional feature.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep.
- idle  in  1  FIFO datapath idle; a sweep only begins while high.
- valid_cont  in  1  counter response valid.
- data_cont  in  BUFFER_DEPTH  counter response value.
- req  out  1  request to counter, one-cycle pulse per index.
- idx  out  IDX_WIDTH  index being requested; held stable from REQ through RESP.
- busy  out  1  high from sweep acceptance until done.
- rd_valid  out  1  one-cycle pulse: rd_idx/rd_data valid.
- rd_idx  out  IDX_WIDTH  index of captured count.
- rd_data  out  BUFFER_DEPTH  captured count.
- total  out  BUFFER_DEPTH+IDX_WIDTH  sum of counts of the current/last sweep.
- done  out  1  one-cycle pulse at sweep end.
- err  out  1  sticky timeout flag; present only with the optional feature.

Behaviour:
- Reset, asynchronous: state=IDLE; req=0, idx=0, busy=0, rd_valid=0, rd_idx=0, rd_data=0, total=0, done=0, err=0.
- Reset asserted mid-sweep aborts it immediately; no done pulse is produced.
- Registered outputs only; no combinational input-to-output paths.

FSM states and transitions:
- IDLE: start=1 and idle=1 -> REQ. start=1 and idle=0 -> ARM. Otherwise stay.
- ARM: busy=1; waits for idle=1 -> REQ. Further start pulses are ignored.
- REQ: req=1 for exactly one cycle with current idx -> RESP.
- RESP: req=0; on valid_cont=1, capture data_cont.
  - Next cycle: rd_valid=1, rd_idx=idx, rd_data=captured value, total += captured value.
  - If idx==NUM_FIFOS-1 -> DONE; otherwise idx+1 -> REQ.
- DONE: done=1 for one cycle, busy=0, idx returns to 0 -> IDLE.

Timing and counting rules:
- Latency: start (idle=1) at cycle T gives req at T+1. Each index costs 2 cycles minimum (REQ + RESP with immediate valid_cont).
- Minimum sweep with NUM_FIFOS=4: done at T+9.
- total clears to 0 on sweep acceptance (IDLE->REQ/ARM) and holds its value after done until the next sweep.
- total width cannot overflow: NUM_FIFOS*(2**BUFFER_DEPTH-1) fits in BUFFER_DEPTH+IDX_WIDTH bits.
- idx wraps only via DONE, never by arithmetic overflow.

Boundary conditions:
- start while busy: ignored, no queuing.
- valid_cont outside RESP, including the REQ cycle: ignored.
- valid_cont held high for several cycles: only the first cycle in RESP is captured.
- idle dropping mid-sweep: ignored; it gates only the start of a sweep.
- start and reset together: reset wins.

Optional Feature:
- Macro: COUNTER_SWEEP_TIMEOUT_EN.
- Enabled:
  - A wait counter (ceil(log2(TIMEOUT_CYCLES+1)) bits) clears on REQ and increments each RESP cycle without valid_cont.
  - At TIMEOUT_CYCLES it records 0 for that index: rd_valid pulses with rd_data=0, total is unchanged, err is set sticky.
  - The sweep then proceeds normally; err clears only on reset or on the next sweep acceptance.
- Disabled: no err port, no wait counter; RESP waits indefinitely for valid_cont.

Decomposition:
- Shared package (counter_pkg): FSM state encoding localparams (IDLE, ARM, REQ, RESP, DONE, 3 bits) and the default BUFFER_DEPTH/IDX_WIDTH constants used by the counter and this block.
- One natural sub-module: sweep_accum, holding the capture register, rd_* outputs and the total adder/clear logic. The FSM stays in the top module.

Test Plan:
- Basic sweep: idle=1, start at T; model answers valid_cont one cycle after req with counts 3,0,7,255 -> req at T+1,T+3,T+5,T+7; rd_idx 0..3 with rd_data 3,0,7,255; total=265; done at T+9; busy low after.
- Arm wait: idle=0, start; hold idle=0 for 5 cycles, then 1 -> busy=1 throughout, req 1 cycle after idle rises, then a normal sweep.
- Slow counter: valid_cont 4 cycles after each req -> idx stable, req single-cycle each index, captures correct, done after 4*5+1 cycles.
- Ignored inputs: start pulsed mid-sweep, valid_cont pulsed while in IDLE and in the REQ cycle -> no second sweep, no spurious rd_valid, total unaffected.
- Reset mid-sweep: assert reset during RESP of idx=2 -> all outputs 0 immediately (asynchronous), no done; new start gives a clean sweep from idx 0 with total restarted.
- Timeout (macro defined, TIMEOUT_CYCLES=15): no valid_cont for idx=1 -> after 15 RESP cycles rd_valid with rd_idx=1, rd_data=0, err=1; sweep completes, total excludes idx 1; err clears at next start.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the FIFO push counter and its sweep controller:
// FSM state encoding and default count/index widths.
package counter_pkg;

    localparam int unsigned DEF_BUFFER_DEPTH = 8;
    localparam int unsigned DEF_IDX_WIDTH    = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        REQ  = 3'd2,
        RESP = 3'd3,
        DONE = 3'd4
    } sweep_state_e;

endpackage

// File: rtl/sweep_accum.sv
// Capture register and running total for the counter sweep: latches each
// returned count for one cycle on rd_* and accumulates it into total.
module sweep_accum
    import counter_pkg::*;
#(
    parameter int unsigned BUFFER_DEPTH = DEF_BUFFER_DEPTH,
    parameter int unsigned IDX_WIDTH    = DEF_IDX_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear_i,
    input  logic                              cap_i,
    input  logic [IDX_WIDTH-1:0]              cap_idx_i,
    input  logic [BUFFER_DEPTH-1:0]           cap_data_i,
    output logic                              rd_valid_o,
    output logic [IDX_WIDTH-1:0]              rd_idx_o,
    output logic [BUFFER_DEPTH-1:0]           rd_data_o,
    output logic [BUFFER_DEPTH+IDX_WIDTH-1:0] total_o
);

    localparam int unsigned TW = BUFFER_DEPTH + IDX_WIDTH;

    logic                    rd_valid_q, rd_valid_d;
    logic [IDX_WIDTH-1:0]    rd_idx_q, rd_idx_d;
    logic [BUFFER_DEPTH-1:0] rd_data_q, rd_data_d;
    logic [TW-1:0]           total_q, total_d;

    always_comb begin
        rd_valid_d = cap_i;
        rd_idx_d   = rd_idx_q;
        rd_data_d  = rd_data_q;
        total_d    = total_q;
        if (clear_i) begin
            total_d = '0;
        end else if (cap_i) begin
            rd_idx_d  = cap_idx_i;
            rd_data_d = cap_data_i;
            total_d   = total_q + TW'(cap_data_i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_idx_q   <= '0;
            rd_data_q  <= '0;
            total_q    <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_idx_q   <= rd_idx_d;
            rd_data_q  <= rd_data_d;
            total_q    <= total_d;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_idx_o   = rd_idx_q;
    assign rd_data_o  = rd_data_q;
    assign total_o    = total_q;

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweeps every FIFO index of the push counter block, streaming counts out and summing them.
// Define COUNTER_SWEEP_TIMEOUT_EN to add the response timeout and the sticky err output.
module counter_sweep_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned BUFFER_DEPTH   = DEF_BUFFER_DEPTH,
    parameter int unsigned IDX_WIDTH      = DEF_IDX_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              idle,
    input  logic                              valid_cont,
    input  logic [BUFFER_DEPTH-1:0]           data_cont,
    output logic                              req,
    output logic [IDX_WIDTH-1:0]              idx,
    output logic                              busy,
    output logic                              rd_valid,
    output logic [IDX_WIDTH-1:0]              rd_idx,
    output logic [BUFFER_DEPTH-1:0]           rd_data,
    output logic [BUFFER_DEPTH+IDX_WIDTH-1:0] total,
`ifdef COUNTER_SWEEP_TIMEOUT_EN
    output logic                              err,
`endif
    output logic                              done
);

    localparam int unsigned          NUM_FIFOS = 2 ** IDX_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_FIFOS - 1);

    sweep_state_e         state_q, state_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic                 req_q, req_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 timeout;
    logic                 resp_hit;
    logic [BUFFER_DEPTH-1:0] cap_data;

    assign accept   = (state_q == IDLE) && start;
    assign resp_hit = (state_q == RESP) && (valid_cont || timeout);
    assign cap_data = timeout ? '0 : data_cont;

`ifdef COUNTER_SWEEP_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;

    // Fires on the TIMEOUT_CYCLES-th RESP cycle without a response.
    assign timeout = (state_q == RESP) && !valid_cont &&
                     (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_d = wait_q;
        if (state_q == REQ) begin
            wait_d = '0;
        end else if ((state_q == RESP) && !valid_cont) begin
            wait_d = wait_q + 1'b1;
        end
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = idle ? REQ : ARM;
                end
            end
            ARM: begin
                if (idle) begin
                    state_d = REQ;
                end
            end
            REQ: state_d = RESP;
            RESP: begin
                if (resp_hit) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        state_d = REQ;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        req_d  = (state_d == REQ);
        busy_d = (state_d == ARM) || (state_d == REQ) || (state_d == RESP);
        done_d = (state_d == DONE);
    end

    assign req  = req_q;
    assign idx  = idx_q;
    assign busy = busy_q;
    assign done = done_q;

    sweep_accum #(
        .BUFFER_DEPTH (BUFFER_DEPTH),
        .IDX_WIDTH    (IDX_WIDTH)
    ) u_accum (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (accept),
        .cap_i      (resp_hit),
        .cap_idx_i  (idx_q),
        .cap_data_i (cap_data),
        .rd_valid_o (rd_valid),
        .rd_idx_o   (rd_idx),
        .rd_data_o  (rd_data),
        .total_o    (total)
    );

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl; the timeout section runs only with
// COUNTER_SWEEP_TIMEOUT_EN defined.
module tb_counter_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       idle;
    logic       valid_cont;
    logic [7:0] data_cont;
    logic       req;
    logic [1:0] idx;
    logic       busy;
    logic       rd_valid;
    logic [1:0] rd_idx;
    logic [7:0] rd_data;
    logic [9:0] total;
    logic       done;
`ifdef COUNTER_SWEEP_TIMEOUT_EN
    logic       err;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t0    = 0;

    always #5 clk = ~clk;

    counter_sweep_ctrl #(
        .BUFFER_DEPTH   (8),
        .IDX_WIDTH      (2),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .idle       (idle),
        .valid_cont (valid_cont),
        .data_cont  (data_cont),
        .req        (req),
        .idx        (idx),
        .busy       (busy),
        .rd_valid   (rd_valid),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .total      (total),
`ifdef COUNTER_SWEEP_TIMEOUT_EN
        .err        (err),
`endif
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Entered in the REQ cycle; answers lat cycles after req and checks the rd_* beat.
    task automatic serve(input int lat, input logic [7:0] d, input int ei, input int et,
                         input bit hold);
        check("req_pulse", req, 1);
        check("req_idx", idx, ei);
        check("busy_sweep", busy, 1);
        for (int k = 1; k < lat; k++) begin
            tick();
            check("wait_req_low", req, 0);
            check("wait_idx_stable", idx, ei);
            check("wait_no_rdv", rd_valid, 0);
        end
        tick();
        check("resp_req_low", req, 0);
        valid_cont = 1'b1;
        data_cont  = d;
        tick();
        if (!hold) valid_cont = 1'b0;
        check("rd_valid", rd_valid, 1);
        check("rd_idx", rd_idx, ei);
        check("rd_data", rd_data, d);
        check("total", total, et);
    endtask

    task automatic finish_sweep(input int et);
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        tick();
        check("done_one_cycle", done, 0);
        check("rdv_after_done", rd_valid, 0);
        check("total_hold", total, et);
        check("busy_after", busy, 0);
    endtask

    task automatic begin_sweep();
        idle  = 1'b1;
        start = 1'b1;
        t0    = cyc;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        idle       = 1'b1;
        valid_cont = 1'b0;
        data_cont  = 8'd0;
        tick();
        tick();
        check("rst_req", req, 0);
        check("rst_idx", idx, 0);
        check("rst_busy", busy, 0);
        check("rst_rdv", rd_valid, 0);
        check("rst_rd_idx", rd_idx, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_total", total, 0);
        check("rst_done", done, 0);
`ifdef COUNTER_SWEEP_TIMEOUT_EN
        check("rst_err", err, 0);
`endif
        reset = 1'b0;
        tick();

        // Basic sweep: 3,0,7,255
        begin_sweep();
        serve(1, 8'd3,   0, 3,   0);
        serve(1, 8'd0,   1, 3,   0);
        serve(1, 8'd7,   2, 10,  0);
        serve(1, 8'd255, 3, 265, 0);
        check("basic_done_latency", cyc - t0, 9);
        finish_sweep(265);

        // Arm wait with idle low for 5 cycles
        idle  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("arm_busy", busy, 1);
        check("arm_total_clear", total, 0);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) start = 1'b1;
            tick();
            start = 1'b0;
            check("arm_busy_hold", busy, 1);
            check("arm_no_req", req, 0);
        end
        idle = 1'b1;
        tick();
        serve(1, 8'd100, 0, 100, 0);
        idle = 1'b0;
        serve(1, 8'd50,  1, 150, 0);
        serve(1, 8'd25,  2, 175, 0);
        serve(1, 8'd12,  3, 187, 0);
        finish_sweep(187);

        // Slow counter: 4 cycles per answer
        tick();
        begin_sweep();
        serve(4, 8'd9, 0, 9,  0);
        serve(4, 8'd8, 1, 17, 0);
        serve(4, 8'd7, 2, 24, 0);
        serve(4, 8'd6, 3, 30, 0);
        check("slow_done_latency", cyc - t0, 21);
        finish_sweep(30);

        // Ignored inputs
        valid_cont = 1'b1;
        data_cont  = 8'h55;
        tick();
        valid_cont = 1'b0;
        check("idle_valid_no_rdv", rd_valid, 0);
        check("idle_valid_total", total, 30);
        check("idle_valid_no_busy", busy, 0);
        begin_sweep();
        check("glitch_req", req, 1);
        valid_cont = 1'b1;
        data_cont  = 8'hAA;
        tick();
        valid_cont = 1'b0;
        check("req_cycle_valid_no_rdv", rd_valid, 0);
        tick();
        check("req_cycle_valid_no_rdv2", rd_valid, 0);
        valid_cont = 1'b1;
        data_cont  = 8'd5;
        tick();
        valid_cont = 1'b0;
        check("glitch_rd_data", rd_data, 5);
        check("glitch_total", total, 5);
        start = 1'b1;
        serve(1, 8'd10, 1, 15, 0);
        start = 1'b0;
        serve(1, 8'd20, 2, 35, 0);
        serve(1, 8'd40, 3, 75, 1);
        finish_sweep(75);
        check("held_valid_no_restart", req, 0);
        tick();
        valid_cont = 1'b0;
        check("held_valid_no_rdv", rd_valid, 0);
        check("no_second_sweep", busy, 0);
        check("held_valid_total", total, 75);

        // Reset during RESP of idx 2
        begin_sweep();
        serve(1, 8'd9, 0, 9,  0);
        serve(1, 8'd8, 1, 17, 0);
        tick();
        check("pre_reset_idx", idx, 2);
        reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_idx", idx, 0);
        check("arst_total", total, 0);
        check("arst_rd_data", rd_data, 0);
        check("arst_rd_idx", rd_idx, 0);
        check("arst_req", req, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_start_busy", busy, 0);
        check("rst_start_req", req, 0);
        check("rst_no_done", done, 0);
        tick();
        check("rst_no_done2", done, 0);
        reset = 1'b0;
        tick();
        begin_sweep();
        check("restart_total", total, 0);
        serve(1, 8'd1, 0, 1,  0);
        serve(1, 8'd2, 1, 3,  0);
        serve(1, 8'd3, 2, 6,  0);
        serve(1, 8'd4, 3, 10, 0);
        finish_sweep(10);

`ifdef COUNTER_SWEEP_TIMEOUT_EN
        // Timeout on idx 1
        begin_sweep();
        check("to_err_start", err, 0);
        serve(1, 8'd6, 0, 6, 0);
        check("to_req_idx1", idx, 1);
        for (int k = 1; k <= 15; k++) begin
            tick();
            check("to_wait_no_rdv", rd_valid, 0);
            check("to_wait_no_err", err, 0);
            check("to_wait_idx", idx, 1);
        end
        tick();
        check("to_rdv", rd_valid, 1);
        check("to_rd_idx", rd_idx, 1);
        check("to_rd_data", rd_data, 0);
        check("to_total", total, 6);
        check("to_err", err, 1);
        serve(1, 8'd7, 2, 13, 0);
        serve(1, 8'd8, 3, 21, 0);
        finish_sweep(21);
        check("to_err_sticky", err, 1);
        tick();
        begin_sweep();
        check("to_err_cleared", err, 0);
        check("to_total_cleared", total, 0);
        serve(1, 8'd1, 0, 1, 0);
        serve(1, 8'd1, 1, 2, 0);
        serve(1, 8'd1, 2, 3, 0);
        serve(1, 8'd1, 3, 4, 0);
        finish_sweep(4);
        check("to_err_clean", err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
